// File: rtl/datapath_controller.sv
// Purpose : multi-cycle FSM controller for the R-type/branch datapath (fetch, decode, execute/branch, writeback).
// Latency : FETCH-to-FETCH is 4 cycles for R-type and 3 cycles for branches, counted from the accepting FETCH edge.
// Backpr. : FETCH stalls with pc held while instr_valid is low; instr_valid is ignored in every other state.
//
// Ports:
//   clk, reset (sync, active-low)     - clocking; reset forces FETCH, pc=RESET_PC, clears IR and illegal
//   instr[XLEN], instr_valid          - instruction word at pc from instruction memory
//   isZero, isBLT, isBGT              - datapath comparison flags used to resolve branches
//   fetch_req, pc[XLEN]               - fetch request and registered fetch address
//   pcNext[XLEN]                      - combinational value pc takes at the next edge
//   regWrite, alucontrol[ALUCTL_W]    - register-file write pulse and ALU operation select
//   illegal                           - sticky trap flag, cleared only by reset
// Optional feature macro: DATAPATH_CTRL_BGT_EN (funct3 110 = BGT, 111 = BLE, using isBGT).

module datapath_controller #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int              ALUCTL_W = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [XLEN-1:0]     instr,
  input  logic                instr_valid,
  input  logic                isZero,
  input  logic                isBLT,
  input  logic                isBGT,
  output logic                fetch_req,
  output logic [XLEN-1:0]     pc,
  output logic [XLEN-1:0]     pcNext,
  output logic                regWrite,
  output logic [ALUCTL_W-1:0] alucontrol,
  output logic                illegal
);

  // Instruction word viewed through its R/B-type fields.
  typedef struct packed {
    logic [6:0] funct7;
    logic [4:0] rs2;
    logic [4:0] rs1;
    logic [2:0] funct3;
    logic [4:0] rd;
    logic [6:0] opcode;
  } instr_t;

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXECUTE,
    S_WRITEBACK,
    S_BRANCH,
    S_TRAP
  } state_t;

  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] F7_ZERO   = 7'b0000000;
  localparam logic [6:0] F7_ALT    = 7'b0100000;

  localparam logic [ALUCTL_W-1:0] ALU_ADD  = ALUCTL_W'(4'b0000);
  localparam logic [ALUCTL_W-1:0] ALU_SUB  = ALUCTL_W'(4'b0001);
  localparam logic [ALUCTL_W-1:0] ALU_AND  = ALUCTL_W'(4'b0010);
  localparam logic [ALUCTL_W-1:0] ALU_OR   = ALUCTL_W'(4'b0011);
  localparam logic [ALUCTL_W-1:0] ALU_XOR  = ALUCTL_W'(4'b0100);
  localparam logic [ALUCTL_W-1:0] ALU_SLL  = ALUCTL_W'(4'b0101);
  localparam logic [ALUCTL_W-1:0] ALU_SRL  = ALUCTL_W'(4'b0110);
  localparam logic [ALUCTL_W-1:0] ALU_SRA  = ALUCTL_W'(4'b0111);
  localparam logic [ALUCTL_W-1:0] ALU_SLT  = ALUCTL_W'(4'b1000);
  localparam logic [ALUCTL_W-1:0] ALU_SLTU = ALUCTL_W'(4'b1001);

  state_t                state;
  instr_t                ir;
  logic                  fetch_req_q;
  logic                  reg_write_q;
  logic [ALUCTL_W-1:0]   alu_q;

  logic [ALUCTL_W-1:0]   alu_sel;
  logic                  rtype_ok;
  logic                  br_ok;
  logic                  br_taken;
  logic [XLEN-1:0]       br_off;
  logic [XLEN-1:0]       pc_plus4;
  logic [XLEN-1:0]       pc_next_c;

  // rs1/rs2 are consumed by the datapath directly, not by the controller.
  logic                  unused_regsel;
  assign unused_regsel = ^{ir.rs1, ir.rs2};

`ifndef DATAPATH_CTRL_BGT_EN
  logic                  unused_bgt;
  assign unused_bgt = isBGT;
`endif

  // ALU select from funct3; funct7[5] picks SUB over ADD and SRA over SRL.
  always_comb begin
    alu_sel = ALU_ADD;
    case (ir.funct3)
      3'b000:  alu_sel = ir.funct7[5] ? ALU_SUB : ALU_ADD;
      3'b001:  alu_sel = ALU_SLL;
      3'b010:  alu_sel = ALU_SLT;
      3'b011:  alu_sel = ALU_SLTU;
      3'b100:  alu_sel = ALU_XOR;
      3'b101:  alu_sel = ir.funct7[5] ? ALU_SRA : ALU_SRL;
      3'b110:  alu_sel = ALU_OR;
      default: alu_sel = ALU_AND;
    endcase
  end

  // funct7=0100000 is only meaningful for SUB and SRA.
  assign rtype_ok = (ir.funct7 == F7_ZERO) ||
                    ((ir.funct7 == F7_ALT) && ((ir.funct3 == 3'b000) || (ir.funct3 == 3'b101)));

  // Branch condition; unsupported funct3 clears br_ok and sends the FSM to TRAP.
  always_comb begin
    br_ok    = 1'b1;
    br_taken = 1'b0;
    case (ir.funct3)
      3'b000:  br_taken = isZero;
      3'b001:  br_taken = !isZero;
      3'b100:  br_taken = isBLT;
      3'b101:  br_taken = !isBLT;
`ifdef DATAPATH_CTRL_BGT_EN
      3'b110:  br_taken = isBGT;
      3'b111:  br_taken = !isBGT;
`endif
      default: br_ok = 1'b0;
    endcase
  end

  // B-type immediate: {IR[31], IR[7], IR[30:25], IR[11:8], 0}, sign-extended.
  assign br_off = {{(XLEN-13){ir.funct7[6]}}, ir.funct7[6], ir.rd[0],
                   ir.funct7[5:0], ir.rd[4:1], 1'b0};

  assign pc_plus4 = pc + XLEN'(4);

  // pcNext moves only in WRITEBACK and in a resolvable BRANCH; a branch that
  // is about to trap leaves pc frozen.
  always_comb begin
    pc_next_c = pc;
    if (!reset) begin
      pc_next_c = RESET_PC;
    end else if (state == S_WRITEBACK) begin
      pc_next_c = pc_plus4;
    end else if ((state == S_BRANCH) && br_ok) begin
      pc_next_c = br_taken ? (pc + br_off) : pc_plus4;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= S_FETCH;
      pc          <= RESET_PC;
      ir          <= '0;
      illegal     <= 1'b0;
      fetch_req_q <= 1'b1;
      reg_write_q <= 1'b0;
      alu_q       <= ALU_ADD;
    end else begin
      // regWrite is a single-cycle pulse; only the EXECUTE->WRITEBACK edge sets it.
      reg_write_q <= 1'b0;
      case (state)
        S_FETCH: begin
          if (instr_valid) begin
            ir          <= instr[31:0];
            state       <= S_DECODE;
            fetch_req_q <= 1'b0;
          end
        end
        S_DECODE: begin
          case (ir.opcode)
            OP_RTYPE: begin
              state <= S_EXECUTE;
              alu_q <= alu_sel;
            end
            OP_BRANCH: begin
              state <= S_BRANCH;
              alu_q <= ALU_SUB;
            end
            default: begin
              state   <= S_TRAP;
              illegal <= 1'b1;
            end
          endcase
        end
        S_EXECUTE: begin
          if (rtype_ok) begin
            state       <= S_WRITEBACK;
            reg_write_q <= (ir.rd != 5'd0);
          end else begin
            state   <= S_TRAP;
            illegal <= 1'b1;
          end
        end
        S_WRITEBACK: begin
          pc          <= pc_next_c;
          state       <= S_FETCH;
          fetch_req_q <= 1'b1;
        end
        S_BRANCH: begin
          if (br_ok) begin
            pc          <= pc_next_c;
            state       <= S_FETCH;
            fetch_req_q <= 1'b1;
          end else begin
            state   <= S_TRAP;
            illegal <= 1'b1;
          end
        end
        S_TRAP: begin
          state <= S_TRAP;
        end
        default: begin
          state   <= S_TRAP;
          illegal <= 1'b1;
        end
      endcase
    end
  end

  // Reset is synchronous but the control outputs must read idle while it is low.
  assign fetch_req  = reset & fetch_req_q;
  assign regWrite   = reset & reg_write_q;
  assign alucontrol = reset ? alu_q : '0;
  assign pcNext     = pc_next_c;

endmodule

// File: tb/tb_datapath_controller.sv
module tb_datapath_controller;

  logic        clk;
  logic        reset;
  logic [31:0] instr;
  logic        instr_valid;
  logic        isZero;
  logic        isBLT;
  logic        isBGT;
  logic        fetch_req;
  logic [31:0] pc;
  logic [31:0] pcNext;
  logic        regWrite;
  logic [3:0]  alucontrol;
  logic        illegal;

  datapath_controller #(
    .XLEN(32),
    .RESET_PC(32'h0000_0000),
    .ALUCTL_W(4)
  ) dut (
    .clk(clk),
    .reset(reset),
    .instr(instr),
    .instr_valid(instr_valid),
    .isZero(isZero),
    .isBLT(isBLT),
    .isBGT(isBGT),
    .fetch_req(fetch_req),
    .pc(pc),
    .pcNext(pcNext),
    .regWrite(regWrite),
    .alucontrol(alucontrol),
    .illegal(illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] instr;
    logic        z;
    logic        lt;
    logic        gt;
    logic        trap;
    int          cyc;
    logic [3:0]  alu;
    int          rw;
    logic [31:0] delta;
  } vec_t;

  vec_t        tbl[$];
  int          checks;
  int          errors;
  logic [31:0] exp_pc;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic [31:0] i, input logic z, input logic lt, input logic gt,
                              input logic trap, input int cyc, input logic [3:0] alu,
                              input int rw, input logic [31:0] delta);
    vec_t v;
    v.instr = i; v.z = z; v.lt = lt; v.gt = gt; v.trap = trap;
    v.cyc = cyc; v.alu = alu; v.rw = rw; v.delta = delta;
    return v;
  endfunction

  // Entered and left at a negedge with the DUT in FETCH (or just released from reset after a trap).
  task automatic run_vec(input vec_t v, input int idx);
    int          n;
    int          rw_cnt;
    logic        done;
    logic [3:0]  last_alu;
    logic [31:0] last_nxt;
    string       tag;
    tag = $sformatf("v%0d", idx);
    chk({tag, " fetch_req at issue"}, {31'd0, fetch_req}, 32'd1);
    chk({tag, " pc at issue"}, pc, exp_pc);
    instr = v.instr; instr_valid = 1'b1;
    isZero = v.z; isBLT = v.lt; isBGT = v.gt;
    n = 0; rw_cnt = 0; done = 1'b0; last_alu = 4'hx; last_nxt = 32'hx;
    while (!done && n < 10) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      // Junk on the bus outside FETCH must be ignored.
      instr = 32'hFFFF_FFFF; instr_valid = 1'b1;
      if (regWrite) rw_cnt++;
      if (fetch_req || illegal) done = 1'b1;
      else begin
        last_alu = alucontrol;
        last_nxt = pcNext;
      end
    end
    instr_valid = 1'b0;
    chk({tag, " completed within budget"}, {31'd0, done}, 32'd1);
    chk({tag, " cycles"}, n, v.cyc);
    chk({tag, " illegal"}, {31'd0, illegal}, {31'd0, v.trap});
    chk({tag, " regWrite pulses"}, rw_cnt, v.rw);
    if (!v.trap) begin
      chk({tag, " alucontrol"}, {28'd0, last_alu}, {28'd0, v.alu});
      chk({tag, " pcNext"}, last_nxt, exp_pc + v.delta);
      exp_pc = exp_pc + v.delta;
      chk({tag, " pc after"}, pc, exp_pc);
    end else begin
      for (int k = 0; k < 20; k++) begin
        chk({tag, " trap hold"}, {29'd0, illegal, fetch_req, regWrite}, 32'b100);
        chk({tag, " trap pc frozen"}, pc, exp_pc);
        @(negedge clk);
      end
      reset = 1'b0;
      #1;
      chk({tag, " pcNext in reset"}, pcNext, 32'h0);
      chk({tag, " fetch_req in reset"}, {31'd0, fetch_req}, 32'd0);
      @(posedge clk);
      @(negedge clk);
      reset = 1'b1;
      #1;
      chk({tag, " illegal cleared"}, {31'd0, illegal}, 32'd0);
      chk({tag, " pc after reset"}, pc, 32'h0);
      chk({tag, " fetch_req resumes"}, {31'd0, fetch_req}, 32'd1);
      exp_pc = 32'h0;
    end
  endtask

  initial begin
    checks = 0; errors = 0; exp_pc = 32'h0;
    reset = 1'b0; instr = 32'h002081B3; instr_valid = 1'b1;
    isZero = 1'b0; isBLT = 1'b0; isBGT = 1'b0;

    //            instr        z  lt gt trap cyc alu     rw delta
    tbl.push_back(mk(32'h002081B3, 0, 0, 0, 0, 4, 4'b0000, 1, 32'd4)); // add x3
    tbl.push_back(mk(32'h402081B3, 0, 0, 0, 0, 4, 4'b0001, 1, 32'd4)); // sub
    tbl.push_back(mk(32'h00208033, 0, 0, 0, 0, 4, 4'b0000, 0, 32'd4)); // add x0
    tbl.push_back(mk(32'h0020F1B3, 0, 0, 0, 0, 4, 4'b0010, 1, 32'd4)); // and
    tbl.push_back(mk(32'h0020E1B3, 0, 0, 0, 0, 4, 4'b0011, 1, 32'd4)); // or
    tbl.push_back(mk(32'h0020C1B3, 0, 0, 0, 0, 4, 4'b0100, 1, 32'd4)); // xor
    tbl.push_back(mk(32'h002091B3, 0, 0, 0, 0, 4, 4'b0101, 1, 32'd4)); // sll
    tbl.push_back(mk(32'h0020D1B3, 0, 0, 0, 0, 4, 4'b0110, 1, 32'd4)); // srl
    tbl.push_back(mk(32'h4020D1B3, 0, 0, 0, 0, 4, 4'b0111, 1, 32'd4)); // sra
    tbl.push_back(mk(32'h0020A1B3, 0, 0, 0, 0, 4, 4'b1000, 1, 32'd4)); // slt
    tbl.push_back(mk(32'h0020B1B3, 0, 0, 0, 0, 4, 4'b1001, 1, 32'd4)); // sltu
    tbl.push_back(mk(32'h402091B3, 0, 0, 0, 1, 3, 4'b0000, 0, 32'd0)); // sll with funct7 0100000: trap
    tbl.push_back(mk(32'hFE209EE3, 0, 0, 0, 0, 3, 4'b0001, 0, 32'hFFFF_FFFC)); // bne -4 from 0: wrap
    tbl.push_back(mk(32'h002081B3, 0, 0, 0, 0, 4, 4'b0000, 1, 32'd4)); // add wraps pc back to 0
    tbl.push_back(mk(32'h00208463, 1, 0, 0, 0, 3, 4'b0001, 0, 32'd8)); // beq taken
    tbl.push_back(mk(32'h00208463, 0, 0, 0, 0, 3, 4'b0001, 0, 32'd4)); // beq not taken
    tbl.push_back(mk(32'hFE209EE3, 1, 0, 0, 0, 3, 4'b0001, 0, 32'd4)); // bne not taken
    tbl.push_back(mk(32'h0020C463, 0, 1, 0, 0, 3, 4'b0001, 0, 32'd8)); // blt taken
    tbl.push_back(mk(32'h0020C463, 1, 0, 1, 0, 3, 4'b0001, 0, 32'd4)); // blt not taken
    tbl.push_back(mk(32'h0020D463, 0, 0, 1, 0, 3, 4'b0001, 0, 32'd8)); // bge taken
    tbl.push_back(mk(32'h0020D463, 0, 1, 0, 0, 3, 4'b0001, 0, 32'd4)); // bge not taken
`ifdef DATAPATH_CTRL_BGT_EN
    tbl.push_back(mk(32'h0020E463, 0, 0, 1, 0, 3, 4'b0001, 0, 32'd8)); // bgt taken
    tbl.push_back(mk(32'h0020E463, 0, 1, 0, 0, 3, 4'b0001, 0, 32'd4)); // bgt not taken
    tbl.push_back(mk(32'h0020F463, 0, 1, 0, 0, 3, 4'b0001, 0, 32'd8)); // ble taken
    tbl.push_back(mk(32'h0020F463, 0, 0, 1, 0, 3, 4'b0001, 0, 32'd4)); // ble not taken
`else
    tbl.push_back(mk(32'h0020E463, 0, 0, 1, 1, 3, 4'b0000, 0, 32'd0)); // funct3 110 traps
    tbl.push_back(mk(32'h0020F463, 0, 0, 0, 1, 3, 4'b0000, 0, 32'd0)); // funct3 111 traps
`endif
    tbl.push_back(mk(32'hFFFFFFFF, 0, 0, 0, 1, 2, 4'b0000, 0, 32'd0)); // bad opcode: trap
    tbl.push_back(mk(32'h022081B3, 0, 0, 0, 1, 3, 4'b0000, 0, 32'd0)); // funct7 0000001: trap
    tbl.push_back(mk(32'h002081B3, 0, 0, 0, 0, 4, 4'b0000, 1, 32'd4)); // add
    tbl.push_back(mk(32'h0020C1B3, 0, 0, 0, 0, 4, 4'b0100, 1, 32'd4)); // xor

    // Reset held low three cycles with a valid instruction on the bus.
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("reset outputs", {alucontrol, illegal, fetch_req, regWrite}, 32'h0);
      chk("reset pcNext", pcNext, 32'h0);
      chk("reset pc", pc, 32'h0);
    end
    instr_valid = 1'b0;
    reset = 1'b1;
    #1;
    chk("post-reset fetch_req", {31'd0, fetch_req}, 32'd1);
    chk("post-reset pc", pc, 32'h0);

    // FETCH stall: instr_valid low for 5 cycles.
    instr = 32'h402081B3;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      @(negedge clk);
      chk("stall fetch_req", {31'd0, fetch_req}, 32'd1);
      chk("stall pc", pc, 32'h0);
      chk("stall pcNext", pcNext, 32'h0);
    end

    for (int i = 0; i < tbl.size(); i++) run_vec(tbl[i], i);

    // Reset asserted during WRITEBACK of an add.
    instr = 32'h002081B3; instr_valid = 1'b1;
    @(posedge clk); @(negedge clk); instr_valid = 1'b0;
    @(posedge clk); @(negedge clk);
    @(posedge clk); @(negedge clk);
    chk("wb regWrite before reset", {31'd0, regWrite}, 32'd1);
    chk("wb pcNext before reset", pcNext, exp_pc + 32'd4);
    reset = 1'b0;
    #1;
    chk("wb regWrite under reset", {31'd0, regWrite}, 32'd0);
    chk("wb pcNext under reset", pcNext, 32'h0);
    chk("wb alucontrol under reset", {28'd0, alucontrol}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("wb pc after reset", pc, 32'h0);
    chk("wb fetch_req after reset", {31'd0, fetch_req}, 32'd1);
    chk("wb regWrite after reset", {31'd0, regWrite}, 32'd0);
    exp_pc = 32'h0;
    run_vec(mk(32'h402081B3, 0, 0, 0, 0, 4, 4'b0001, 1, 32'd4), 99);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/datapath_controller.md
Name: datapath_controller

Overview:
- Multi-cycle control unit for the non-pipelined R-type/branch datapath.
- Fetches the instruction word at `pc` and decodes it.
- Drives the datapath's `regWrite`, `alucontrol` and `pcNext` inputs.
- Consumes the datapath's comparison flags `isZero`, `isBLT` and `isBGT` to resolve branches.

Parameters:
- XLEN, 32: width of pc, pcNext and instruction.
- RESET_PC, 32'h0000_0000: pc value after reset.
- ALUCTL_W, 4: width of `alucontrol`.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- reset  in  1  synchronous reset, active-low (0 = reset).
- instr  in  XLEN  instruction word at `pc` from instruction memory.
- instr_valid  in  1  `instr` valid this cycle.
- isZero  in  1  datapath: rs1 == rs2 (ALU result zero).
- isBLT  in  1  datapath: rs1 < rs2, signed.
- isBGT  in  1  datapath: rs1 > rs2, signed.
- fetch_req  out  1  request instruction at `pc`.
- pc  out  XLEN  current fetch address, registered.
- pcNext  out  XLEN  value `pc` takes at the next edge, combinational.
- regWrite  out  1  register-file write enable, one-cycle pulse.
- alucontrol  out  ALUCTL_W  ALU operation select.
- illegal  out  1  sticky: controller trapped on an unsupported instruction.

Behaviour:
- Reset (reset==0 at an edge), from any state including mid-instruction:
  - state <= FETCH; pc <= RESET_PC; IR <= 0; illegal <= 0.
  - While reset is low: fetch_req=0, regWrite=0, alucontrol=4'b0000, pcNext=RESET_PC.
- ALU encodings:
  - ADD 0000, SUB 0001, AND 0010, OR 0011, XOR 0100.
  - SLL 0101, SRL 0110, SRA 0111, SLT 1000, SLTU 1001.
- FETCH:
  - fetch_req=1.
  - instr_valid=0: hold (pc, state unchanged).
  - instr_valid=1: IR <= instr, go to DECODE.
- DECODE, on IR[6:0]:
  - 0110011 -> EXECUTE.
  - 1100011 -> BRANCH.
  - Anything else -> TRAP.
- EXECUTE:
  - alucontrol is derived from funct3/funct7 and held until the next FETCH.
  - funct7 must be 0000000, or 0100000 only for funct3 000 (SUB) or 101 (SRA).
  - Any other funct7 -> TRAP, regWrite stays 0.
  - Legal encodings -> WRITEBACK.
- WRITEBACK:
  - regWrite=1 for exactly this cycle, only if rd (IR[11:7]) != 0.
  - pcNext = pc+4; pc <= pcNext; then FETCH.
- BRANCH:
  - alucontrol=SUB.
  - Taken condition by funct3:
    - 000 BEQ: isZero.
    - 001 BNE: !isZero.
    - 100 BLT: isBLT.
    - 101 BGE: !isBLT.
  - funct3 010/011/110/111 -> TRAP.
  - Taken: pcNext = pc + sext({IR[31],IR[7],IR[30:25],IR[11:8],1'b0}). Not taken: pcNext = pc+4.
  - pc <= pcNext; then FETCH. regWrite is never asserted in BRANCH.
  - `isBGT` is ignored unless the optional feature is enabled.
- TRAP:
  - illegal=1 (sticky), fetch_req=0, regWrite=0, pc frozen.
  - Exits only via reset.
- Timing and arithmetic:
  - Outside WRITEBACK/BRANCH, pcNext == pc.
  - All pc arithmetic is modulo 2^XLEN; wrap-around is silent.
  - Latency with instr_valid in the first FETCH cycle: R-type 4 cycles, branch 3 cycles, FETCH-to-FETCH.
  - regWrite never asserts in two consecutive cycles.
- instr_valid outside FETCH is ignored.

Optional Feature:
- Macro: DATAPATH_CTRL_BGT_EN.
- When defined:
  - funct3 110 decodes as custom BGT (taken if isBGT).
  - funct3 111 decodes as BLE (taken if !isBGT).
  - Neither traps.
- When undefined: funct3 110/111 trap, and `isBGT` is unconnected internally.

Test Plan:
1. Reset low 3 cycles, then high; instr=0x002081B3 (add x3,x1,x2), instr_valid=1 -> pc=0; EXECUTE alucontrol=0000; regWrite=1 exactly in cycle 4; pc=0x4 at next FETCH.
2. instr=0x402081B3 (sub) with instr_valid held low 5 cycles in FETCH -> pc stays 0, fetch_req=1 throughout; afterwards alucontrol=0001, regWrite pulse once. Then instr=0x00208033 (rd=x0) -> regWrite never asserted, pc advances by 4.
3. pc=0x10, instr=0x00208463 (beq +8):
   - isZero=1 -> pc=0x18, BRANCH alucontrol=0001, no regWrite.
   - Repeat with isZero=0 -> pc=0x14.
4. pc=0, instr=0xFE209EE3 (bne -4), isZero=0 -> pcNext=0xFFFFFFFC (wrap); next fetch address 0xFFFFFFFC.
5. instr=0xFFFFFFFF -> TRAP after DECODE, illegal=1, fetch_req=0 for 20 cycles; reset low 1 cycle -> illegal=0, pc=RESET_PC, FETCH resumes.
6. Reset asserted during WRITEBACK of an add -> regWrite=0 that cycle, pc=RESET_PC, next state FETCH. With DATAPATH_CTRL_BGT_EN, funct3=110 and isBGT=1 -> branch taken, no trap.
